// File: rtl/send_an_flp.sv
// Auto-negotiation FLP transmitter: three 16-bit pages, each sent as BURSTS_PER_PAGE clock/data bursts.
// Optional complementary output an_sgmii_rx_n under macro SEND_AN_FLP_DIFF_OUT_EN.
module send_an_flp #(
   parameter int PULSE_CYC       = 12,
   parameter int SLOT_CYC        = 7812,
   parameter int BURSTS_PER_PAGE = 6,
   parameter int GAP_CYC         = 2000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [47:0] an_config,
   output logic        done,
`ifdef SEND_AN_FLP_DIFF_OUT_EN
   output logic        an_sgmii_rx_n,
`endif
   output logic        an_sgmii_rx_p
);

   localparam int CMAX = (GAP_CYC > SLOT_CYC) ? GAP_CYC : SLOT_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int BW   = (BURSTS_PER_PAGE > 1) ? $clog2(BURSTS_PER_PAGE) : 1;

   typedef enum logic [2:0] {IDLE, HIGH, LOW, GAP, DONE} st_t;

   st_t             st_q, st_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic [5:0]      pos_q, pos_d;
   logic [BW-1:0]   bur_q, bur_d;
   logic [1:0]      pg_q, pg_d;
   logic [47:0]     cfg_q, cfg_d;
   logic            start_q, arm_q;
   logic            edge_w, last_w, pulse_nxt;
   logic [15:0]     word_w;
   logic [5:0]      pos_inc;

   // arm_q blocks a start that was already high when reset released
   assign edge_w  = start & ~start_q & arm_q;
   assign pos_inc = pos_q + 6'd1;
   assign last_w  = (pg_q == 2'd2) && (bur_q == BW'(BURSTS_PER_PAGE - 1));

   always_comb begin
      case (pg_q)
         2'd0:    word_w = cfg_q[47:32];
         2'd1:    word_w = cfg_q[31:16];
         default: word_w = cfg_q[15:0];
      endcase
   end

   // Next slot pulses if it is a clock slot or its data bit is set (bit k at slot 2k+1)
   assign pulse_nxt = ~pos_inc[0] | word_w[pos_inc[4:1]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q    <= IDLE;
         cyc_q   <= '0;
         pos_q   <= '0;
         bur_q   <= '0;
         pg_q    <= '0;
         cfg_q   <= '0;
         start_q <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         cyc_q   <= cyc_d;
         pos_q   <= pos_d;
         bur_q   <= bur_d;
         pg_q    <= pg_d;
         cfg_q   <= cfg_d;
         start_q <= start;
         arm_q   <= arm_q | ~start;
      end
   end

   always_comb begin
      st_d  = st_q;
      cyc_d = cyc_q;
      pos_d = pos_q;
      bur_d = bur_q;
      pg_d  = pg_q;
      cfg_d = cfg_q;
      case (st_q)
         IDLE, DONE: begin
            if (edge_w) begin
               st_d  = HIGH;
               cfg_d = an_config;
               cyc_d = '0;
               pos_d = '0;
               bur_d = '0;
               pg_d  = '0;
            end
         end
         HIGH: begin
            if (cyc_q == CW'(PULSE_CYC - 1)) begin
               if (pos_q == 6'd32) begin
                  cyc_d = '0;
                  pos_d = '0;
                  if (last_w) begin
                     st_d = DONE;
                  end else begin
                     st_d = GAP;
                     if (bur_q == BW'(BURSTS_PER_PAGE - 1)) begin
                        bur_d = '0;
                        pg_d  = pg_q + 2'd1;
                     end else begin
                        bur_d = bur_q + BW'(1);
                     end
                  end
               end else begin
                  st_d  = LOW;
                  cyc_d = cyc_q + CW'(1);
               end
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         LOW: begin
            if (cyc_q == CW'(SLOT_CYC - 1)) begin
               cyc_d = '0;
               pos_d = pos_inc;
               st_d  = pulse_nxt ? HIGH : LOW;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         GAP: begin
            if (cyc_q == CW'(GAP_CYC - 1)) begin
               cyc_d = '0;
               st_d  = HIGH;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_comb begin
      an_sgmii_rx_p = (st_q == HIGH);
      done          = (st_q == DONE);
`ifdef SEND_AN_FLP_DIFF_OUT_EN
      an_sgmii_rx_n = ~(st_q == HIGH);
`endif
   end

endmodule

// File: tb/tb_send_an_flp.sv
// Directed bench for send_an_flp with small timing parameters (pulse 2, slot 8, 2 bursts/page, gap 20).
module tb_send_an_flp;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [47:0] an_config;
   logic        done, an_sgmii_rx_p;
`ifdef SEND_AN_FLP_DIFF_OUT_EN
   logic        an_sgmii_rx_n;
`endif

   int errors = 0;
   int checks = 0;
   int ptot   = 0;
   int dbad   = 0;
   logic prev_p = 1'b0;

   send_an_flp #(.PULSE_CYC(2), .SLOT_CYC(8), .BURSTS_PER_PAGE(2), .GAP_CYC(20)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .an_config(an_config),
      .done(done),
`ifdef SEND_AN_FLP_DIFF_OUT_EN
      .an_sgmii_rx_n(an_sgmii_rx_n),
`endif
      .an_sgmii_rx_p(an_sgmii_rx_p)
   );

   always #5 clk = ~clk;

   // Pulse counter sampled on the inactive edge
   always @(negedge clk) begin
      if (an_sgmii_rx_p && !prev_p) ptot <= ptot + 1;
      prev_p <= an_sgmii_rx_p;
`ifdef SEND_AN_FLP_DIFF_OUT_EN
      if (an_sgmii_rx_n !== ~an_sgmii_rx_p) dbad <= dbad + 1;
`endif
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start edge in cycle 0; runs to cycle 1655 checking pulses, bitmap and done timing
   task automatic run_tx(input string tag, input int exp_pulses, input bit bitmap, input bit mid_start);
      int p0;
      int p;
      logic [15:0] bits;
      bits = 16'b0000_1010_0101_0001;
      start = 1'b0;
      tick();
      p0 = ptot;
      start = 1'b1;
      for (int c = 1; c <= 1655; c++) begin
         tick();
         if (c == 1) begin
            chk({tag, "_first_hi"}, 32'(an_sgmii_rx_p), 32'd1);
            chk({tag, "_done_clr"}, 32'(done), 32'd0);
         end
         if (c == 3) chk({tag, "_width"}, 32'(an_sgmii_rx_p), 32'd0);
         if (bitmap && c <= 257 && ((c - 1) % 8) == 0) begin
            p = (c - 1) / 8;
            chk($sformatf("%s_slot%0d", tag, p), 32'(an_sgmii_rx_p),
                (p % 2 == 0) ? 32'd1 : 32'(bits[(p - 1) / 2]));
         end
         if (mid_start) begin
            if (c == 600) begin
               start = 1'b0;
               an_config = 48'h0;
            end
            if (c == 602) start = 1'b1;
         end
         if (c == 1648) chk({tag, "_done_early"}, 32'(done), 32'd0);
         if (c == 1649) chk({tag, "_done_rise"}, 32'(done), 32'd1);
      end
      chk({tag, "_done_held"}, 32'(done), 32'd1);
      chk({tag, "_pulses"}, 32'(ptot - p0), 32'(exp_pulses));
   endtask

   initial begin
      int p0;
      reset = 1'b1;
      start = 1'b0;
      an_config = 48'h0A51_0221_0100;
      tick();
      tick();
      chk("rst_out", 32'(an_sgmii_rx_p), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      tick();
      tick();

      // reset mid-burst in page0
      start = 1'b1;
      for (int c = 1; c <= 50; c++) tick();
      reset = 1'b1;
      #1;
      chk("midrst_out", 32'(an_sgmii_rx_p), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      tick();
      tick();
      p0 = ptot;
      reset = 1'b0;
      for (int c = 0; c < 400; c++) tick();
      chk("held_start_pulses", 32'(ptot - p0), 32'd0);
      chk("held_start_done", 32'(done), 32'd0);
      tick();

      run_tx("basic", 120, 1'b1, 1'b0);
      start = 1'b0;
      tick();
      tick();
      run_tx("midstart", 120, 1'b1, 1'b1);
      an_config = 48'h0;
      run_tx("restart0", 102, 1'b0, 1'b0);

`ifdef SEND_AN_FLP_DIFF_OUT_EN
      chk("diff_n", 32'(dbad), 32'd0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/send_an_flp.md
SEND_AN_FLP -- requirements
Module: send_an_flp

Interface
REQ-001 Parameter PULSE_CYC, default 12: width of every pulse in clk cycles (100 ns at 125 MHz).
REQ-002 Parameter SLOT_CYC, default 7812: clock-pulse to data-slot spacing in clk cycles (62.5 us); PULSE_CYC < SLOT_CYC required.
REQ-003 Parameter BURSTS_PER_PAGE, default 6: bursts transmitted per 16-bit page; minimum 1.
REQ-004 Parameter GAP_CYC, default 2000000: low time between bursts in clk cycles (16 ms).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  rising edge requests one complete 3-page transmission.
REQ-008 an_config  input  48  three link code words: page0=[47:32], page1=[31:16], page2=[15:0].
REQ-009 done  output  1  high once a transmission completes; held until the next accepted start.
REQ-010 an_sgmii_rx_p  output  1  serial FLP pulse stream; low when idle.

Function
REQ-011 States SHALL be IDLE, HIGH, LOW, GAP, DONE; reset and power-up enter IDLE.
REQ-012 start SHALL be registered once; an edge is detected in cycle N when start=1 and its registered copy=0.
REQ-013 From IDLE or DONE, an edge in cycle N SHALL latch an_config, clear done, and drive an_sgmii_rx_p high from cycle N+1.
REQ-014 An edge while in HIGH, LOW or GAP SHALL be ignored; the latched an_config SHALL NOT change mid-transmission.
REQ-015 A burst SHALL have 33 slot positions p=0..32, each starting SLOT_CYC cycles after the previous one.
REQ-016 Even positions are clock pulses and SHALL always pulse high for exactly PULSE_CYC cycles.
REQ-017 Odd position p=2k+1 SHALL pulse high for PULSE_CYC cycles iff bit k of the current page is 1; otherwise it stays low.
REQ-018 Bit k SHALL be taken LSB-first, so D0 is transmitted first.
REQ-019 A burst SHALL last 32*SLOT_CYC+PULSE_CYC cycles, ending with the falling edge of clock pulse 32.
REQ-020 After each burst except the final one, the output SHALL stay low for exactly GAP_CYC cycles before the next burst starts.
REQ-021 Each page SHALL be sent BURSTS_PER_PAGE consecutive times, in order page0, page1, page2.
REQ-022 After the last burst of page2, done SHALL rise in the first cycle after the final pulse falls, and the FSM SHALL enter DONE.
REQ-023 Counters (cycle, position, burst, page) SHALL be sized from the parameters; no wrap-around within a transmission.
REQ-024 start held high continuously SHALL produce exactly one transmission.

Reset
REQ-025 While reset=1: an_sgmii_rx_p=0, done=0, state=IDLE, counters=0, registered start=0, latched config=0.
REQ-026 Reset asserted mid-transmission SHALL abort it immediately with no further pulses.
REQ-027 After reset release, a start already high SHALL NOT trigger a transmission; a new rising edge is required.

Configuration
REQ-028 With macro SEND_AN_FLP_DIFF_OUT_EN defined, an extra output an_sgmii_rx_n (1 bit) SHALL equal ~an_sgmii_rx_p every cycle, and SHALL be 1 during reset.
REQ-029 With SEND_AN_FLP_DIFF_OUT_EN undefined, the an_sgmii_rx_n port SHALL NOT exist; all other behaviour is identical.

Verification
Bench parameters: PULSE_CYC=2, SLOT_CYC=8, BURSTS_PER_PAGE=2, GAP_CYC=20; an_config=48'h0A51_0221_0100.
REQ-030 Basic transmission: start edge detected in cycle 0 -> output high in cycles 1-2; 120 pulses in total (22/20/18 per burst for pages 0/1/2, each burst twice); done rises at cycle 1+6*258+5*20=1649.
REQ-031 Bit map check: in page0 bursts -> data slots for bits 0,4,6,9,11 pulse and all other data slots stay low.
REQ-032 Start mid-burst: second start edge during page1 -> ignored; pulse count and done timing unchanged from REQ-030.
REQ-033 Reset mid-burst: assert reset in page0 -> output 0 and done 0 immediately; after release with start held high, no pulses occur until start is dropped and raised again.
REQ-034 Restart: after done, a new start edge with an_config=0 -> done clears next cycle; 6 bursts of 17 clock pulses and no data pulses.
REQ-035 With SEND_AN_FLP_DIFF_OUT_EN defined -> an_sgmii_rx_n is the exact complement of an_sgmii_rx_p every cycle during REQ-030.
